// File: rtl/vgg_pool_pkg.sv
// Shared fp32 helpers for the fused ReLU + 2x2 max-pool block.
// The FUSED_RELU_EN macro selects which compare variant the datapath uses.
package vgg_pool_pkg;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    function automatic logic [31:0] fp32_relu(input logic [31:0] x);
        return x[31] ? FP32_ZERO : x;
    endfunction

    // Both operands are known non-negative, so the magnitude bits order them directly.
    function automatic logic fp32_gt_nonneg(input logic [31:0] a, input logic [31:0] b);
        return (a & 32'h7FFF_FFFF) > (b & 32'h7FFF_FFFF);
    endfunction

    // Sign-magnitude ordering; +0.0 and -0.0 are treated as equal.
    function automatic logic fp32_gt_signed(input logic [31:0] a, input logic [31:0] b);
        logic gt;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            gt = 1'b0;
        end else if (a[31] != b[31]) begin
            gt = b[31];
        end else if (a[31]) begin
            gt = a[30:0] < b[30:0];
        end else begin
            gt = a[30:0] > b[30:0];
        end
        return gt;
    endfunction

    function automatic int col_w(input int width);
        return $clog2(width);
    endfunction

    function automatic int row_w(input int height);
        return $clog2(height);
    endfunction

endpackage

// File: rtl/relu_maxpool_nch_fp32_max3.sv
// Combinational 3-input fp32 max for one channel.
// With FUSED_RELU_EN defined, operands are assumed non-negative.
module fp32_max3
    import vgg_pool_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    output logic [31:0] max_o
);

    logic [31:0] ab_s;

    // Pairwise max of a/b, then against c.
    always_comb begin
        ab_s  = a_i;
        max_o = a_i;
`ifdef FUSED_RELU_EN
        ab_s  = fp32_gt_nonneg(b_i, a_i) ? b_i : a_i;
        max_o = fp32_gt_nonneg(c_i, ab_s) ? c_i : ab_s;
`else
        ab_s  = fp32_gt_signed(b_i, a_i) ? b_i : a_i;
        max_o = fp32_gt_signed(c_i, ab_s) ? c_i : ab_s;
`endif
    end

endmodule

// File: rtl/relu_maxpool_nch.sv
// Fused ReLU + 2x2/stride-2 max pooling over CHANNELS packed fp32 channels.
// Define FUSED_RELU_EN to clamp negative inputs to +0.0 before pooling.
module relu_maxpool_nch
    import vgg_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56,
    parameter int CHANNELS   = 8
)
(
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    output logic                           done
);

    localparam int COL_W  = col_w(WIDTH);
    localparam int ROW_W  = row_w(HEIGHT);
    localparam int BUF_AW = (COL_W > 1) ? COL_W - 1 : 1;
    localparam int BUS_W  = CHANNELS * DATA_WIDTH;

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("relu_maxpool_nch: WIDTH must be even and >= 2");
    end
    if ((HEIGHT < 2) || ((HEIGHT % 2) != 0)) begin : g_bad_height
        $error("relu_maxpool_nch: HEIGHT must be even and >= 2");
    end

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [BUS_W-1:0]  prev_q, prev_d;
    logic [BUS_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              buf_we_s;
    logic              col_last_s, row_last_s;
    logic [BUF_AW-1:0] buf_idx_s;
    logic [BUS_W-1:0]  buf_rd_s;
    logic [BUS_W-1:0]  pix_s;
    logic [BUS_W-1:0]  max_s;
    logic [BUS_W-1:0]  line_buf_q [WIDTH/2];

    assign col_last_s = (col_q == COL_W'(WIDTH - 1));
    assign row_last_s = (row_q == ROW_W'(HEIGHT - 1));
    assign buf_idx_s  = BUF_AW'(col_q >> 1);
    assign buf_rd_s   = line_buf_q[buf_idx_s];

    // On even rows the max of (prev, prev, cur) is the pair max stored to the line buffer;
    // on odd rows the buffered pair joins in to complete the window.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
`ifdef FUSED_RELU_EN
        assign pix_s[c*DATA_WIDTH +: DATA_WIDTH] = fp32_relu(data_in[c*DATA_WIDTH +: DATA_WIDTH]);
`else
        assign pix_s[c*DATA_WIDTH +: DATA_WIDTH] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
`endif
        fp32_max3 u_max3 (
            .a_i   (row_q[0] ? buf_rd_s[c*DATA_WIDTH +: DATA_WIDTH]
                             : prev_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .b_i   (prev_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .c_i   (pix_s[c*DATA_WIDTH +: DATA_WIDTH]),
            .max_o (max_s[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Raster counters, prev capture, buffer write enable and output strobe.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        prev_d   = prev_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        buf_we_s = 1'b0;
        if (valid_in) begin
            if (col_last_s) begin
                col_d = '0;
                row_d = row_last_s ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                prev_d = pix_s;
            end else if (!row_q[0]) begin
                buf_we_s = 1'b1;
            end else begin
                data_d  = max_s;
                valid_d = 1'b1;
                done_d  = col_last_s && row_last_s;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q   <= '0;
            row_q   <= '0;
            prev_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line buffer holds even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            line_buf_q[buf_idx_s] <= max_s;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_relu_maxpool_nch.sv
// Directed bench for relu_maxpool_nch at 4x4, 2 channels.
// Expectations follow FUSED_RELU_EN when it is defined for the build.
module tb_relu_maxpool_nch;

    localparam int W = 4;
    localparam int H = 4;
    localparam int C = 2;
`ifdef FUSED_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            valid_in = 1'b0;
    logic [C*32-1:0] data_in = '0;
    logic [C*32-1:0] data_out;
    logic            valid_out;
    logic            done;

    relu_maxpool_nch #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H), .CHANNELS(C)) dut (
        .clk(clk), .resetn(resetn), .valid_in(valid_in), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stray_done = 0;
    logic [31:0] pix0 [16];
    logic [31:0] pix1 [16];
    logic [63:0] obs_d [$];
    logic        obs_done [$];
    int          obs_cyc [$];
    logic [63:0] exp_d [$];
    logic        exp_done [$];
    int          beat_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_out) begin
            obs_d.push_back(data_out);
            obs_done.push_back(done);
            obs_cyc.push_back(cyc);
        end else if (done) begin
            stray_done++;
        end
    end

    function automatic logic [31:0] fp(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0000_0000;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = 32'(n - (1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic void set_ramp(input int base);
        for (int p = 0; p < 16; p++) begin
            pix0[p] = fp(base + p);
            pix1[p] = pix0[p] | 32'h8000_0000;
        end
    endfunction

    // Window (r,c) top-left pixel indices are 0,2,8,10; ch0 max is the bottom-right, ch1 max the top-left.
    function automatic void expect_frame(input int base);
        int tl [4] = '{0, 2, 8, 10};
        logic [31:0] e0, e1;
        for (int w = 0; w < 4; w++) begin
            e0 = fp(base + tl[w] + 5);
            e1 = fp(base + tl[w]);
            e1 = RELU ? 32'h0000_0000 : (e1 | 32'h8000_0000);
            exp_d.push_back({e1, e0});
            exp_done.push_back(w == 3);
        end
    endfunction

    function automatic void clear_q();
        obs_d.delete(); obs_done.delete(); obs_cyc.delete();
        exp_d.delete(); exp_done.delete(); beat_cyc.delete();
    endfunction

    task automatic drive_frame(input bit bubbles);
        for (int p = 0; p < 16; p++) begin
            for (int g = 0; g < 4 && bubbles && ($urandom_range(0, 1) == 0); g++) begin
                @(posedge clk); #1;
                valid_in = 1'b0;
                data_in  = {C*32{1'b1}};
            end
            @(posedge clk); #1;
            valid_in = 1'b1;
            data_in  = {pix1[p], pix0[p]};
            if (((p / 4) % 2 == 1) && ((p % 4) % 2 == 1)) beat_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset valid_out: got %b want 0", valid_out); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else n_pass++;
        n_checks++; if (data_out !== 64'h0) $display("FAIL reset data_out: got %h want 0", data_out); else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_frame();
        clear_q();
        set_ramp(0);
        expect_frame(0);
        drive_frame(1'b0);
        repeat (3) @(posedge clk);
        n_checks++; if (obs_d.size() !== 4) $display("FAIL frame count: got %0d want 4", obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL frame data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
            n_checks++; if (obs_done[i] !== exp_done[i]) $display("FAIL frame done%0d: got %b want %b", i, obs_done[i], exp_done[i]); else n_pass++;
            n_checks++; if (obs_cyc[i] !== beat_cyc[i] + 1) $display("FAIL frame latency%0d: got cyc %0d want %0d", i, obs_cyc[i], beat_cyc[i] + 1); else n_pass++;
        end
    endtask

    task automatic test_bubbles();
        clear_q();
        set_ramp(0);
        expect_frame(0);
        drive_frame(1'b1);
        repeat (3) @(posedge clk);
        n_checks++; if (obs_d.size() !== 4) $display("FAIL bubble count: got %0d want 4", obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL bubble data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
            n_checks++; if (obs_done[i] !== exp_done[i]) $display("FAIL bubble done%0d: got %b want %b", i, obs_done[i], exp_done[i]); else n_pass++;
            n_checks++; if (obs_cyc[i] !== beat_cyc[i] + 1) $display("FAIL bubble latency%0d: got cyc %0d want %0d", i, obs_cyc[i], beat_cyc[i] + 1); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        clear_q();
        expect_frame(0);
        expect_frame(100);
        for (int f = 0; f < 2; f++) begin
            set_ramp(f * 100);
            for (int p = 0; p < 16; p++) begin
                @(posedge clk); #1;
                valid_in = 1'b1;
                data_in  = {pix1[p], pix0[p]};
                if (((p / 4) % 2 == 1) && ((p % 4) % 2 == 1)) beat_cyc.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++; if (obs_d.size() !== 8) $display("FAIL b2b count: got %0d want 8", obs_d.size()); else n_pass++;
        ndone = 0;
        for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
            if (obs_done[i]) ndone++;
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL b2b data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
            n_checks++; if (obs_done[i] !== exp_done[i]) $display("FAIL b2b done%0d: got %b want %b", i, obs_done[i], exp_done[i]); else n_pass++;
            n_checks++; if (obs_cyc[i] !== beat_cyc[i] + 1) $display("FAIL b2b latency%0d: got cyc %0d want %0d", i, obs_cyc[i], beat_cyc[i] + 1); else n_pass++;
        end
        n_checks++; if (ndone !== 2) $display("FAIL b2b done pulses: got %0d want 2", ndone); else n_pass++;
    endtask

    task automatic test_mid_reset();
        set_ramp(0);
        for (int p = 0; p < 6; p++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            data_in  = {pix1[p], pix0[p]};
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        resetn   = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL midrst valid_out: got %b want 0", valid_out); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst done: got %b want 0", done); else n_pass++;
        n_checks++; if (data_out !== 64'h0) $display("FAIL midrst data_out: got %h want 0", data_out); else n_pass++;
        clear_q();
        expect_frame(0);
        drive_frame(1'b0);
        repeat (3) @(posedge clk);
        n_checks++; if (obs_d.size() !== 4) $display("FAIL midrst count: got %0d want 4", obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL midrst data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
            n_checks++; if (obs_done[i] !== exp_done[i]) $display("FAIL midrst done%0d: got %b want %b", i, obs_done[i], exp_done[i]); else n_pass++;
        end
    endtask

    task automatic test_ties();
        logic [31:0] neg0;
        clear_q();
        neg0 = 32'h8000_0000;
        for (int p = 0; p < 16; p++) begin
            pix0[p] = 32'h0000_0000;
            pix1[p] = neg0;
        end
        pix0[1] = neg0;
        pix0[4] = 32'h4020_0000;
        pix0[5] = 32'h4020_0000;
        for (int w = 0; w < 4; w++) begin
            exp_d.push_back({RELU ? 32'h0000_0000 : neg0, (w == 0) ? 32'h4020_0000 : 32'h0000_0000});
            exp_done.push_back(w == 3);
        end
        drive_frame(1'b0);
        repeat (3) @(posedge clk);
        n_checks++; if (obs_d.size() !== 4) $display("FAIL ties count: got %0d want 4", obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL ties data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
        end
        n_checks++; if (stray_done !== 0) $display("FAIL stray done: got %0d want 0", stray_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        test_ties();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
